univ_shift_reg: RTL and testbench

Parametrised universal shift register for the Multi_Register library, generalising the single-bit D flip-flop with clear into a WIDTH-bit storage element. Supports hold, shift right, shift left and parallel load, plus a shift counter that flags when a full word has been serialised. Serves as the common building block for serialisers, deserialisers and staging registers in the datapath.

---
 rtl/univ_shift_reg.sv | 109 ++++++++++
 tb/tb_univ_shift_reg.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// ============================================================================
// Module   : univ_shift_reg
// Purpose  : WIDTH-bit universal shift register with hold, shift right,
//            shift left and parallel load. A saturating shift counter flags
//            when a full word has been serialised.
//            Optional macro USR_ROTATE_EN makes rot=1 wrap the outgoing bit
//            back in during shifts.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module univ_shift_reg #(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}},
  localparam int                CW      = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             rot,
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  localparam logic [1:0]    c_MODE_HOLD  = 2'b00;
  localparam logic [1:0]    c_MODE_SHR   = 2'b01;
  localparam logic [1:0]    c_MODE_SHL   = 2'b10;
  localparam logic [1:0]    c_MODE_LOAD  = 2'b11;
  localparam logic [CW-1:0] c_CNT_MAX    = CW'(WIDTH);

  logic [WIDTH-1:0] q_q,    q_d;
  logic [CW-1:0]    cnt_q,  cnt_d;
  logic             done_q, done_d;
  logic             w_fill_r;
  logic             w_fill_l;
  logic [CW-1:0]    w_cnt_inc;

`ifdef USR_ROTATE_EN
  assign w_fill_r = rot ? q_q[0]       : sin_r;
  assign w_fill_l = rot ? q_q[WIDTH-1] : sin_l;
`else
  logic w_unused_rot;
  assign w_unused_rot = rot;
  assign w_fill_r     = sin_r;
  assign w_fill_l     = sin_l;
`endif

  // Counter stops at WIDTH so done stays asserted across extra shifts.
  assign w_cnt_inc = (cnt_q == c_CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (en) begin
      case (mode)
        c_MODE_SHR: begin
          q_d    = {w_fill_r, q_q[WIDTH-1:1]};
          cnt_d  = w_cnt_inc;
          done_d = (w_cnt_inc == c_CNT_MAX);
        end
        c_MODE_SHL: begin
          q_d    = {q_q[WIDTH-2:0], w_fill_l};
          cnt_d  = w_cnt_inc;
          done_d = (w_cnt_inc == c_CNT_MAX);
        end
        c_MODE_LOAD: begin
          q_d    = d;
          cnt_d  = '0;
          done_d = 1'b0;
        end
        c_MODE_HOLD: begin
          q_d    = q_q;
        end
        default: begin
          q_d    = q_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_q    <= RST_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q    = q_q;
  assign cnt  = cnt_q;
  assign done = done_q;
  assign so_r = q_q[0];
  assign so_l = q_q[WIDTH-1];

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
// ============================================================================
// Module   : tb_univ_shift_reg
// Purpose  : Directed self-checking bench for univ_shift_reg (WIDTH=8).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH+1);

  logic             clk;
  logic             clr;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_r;
  logic             sin_l;
  logic             rot;
  logic [WIDTH-1:0] q;
  logic             so_r;
  logic             so_l;
  logic [CW-1:0]    cnt;
  logic             done;

  int n_pass  = 0;
  int n_total = 0;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .clr   (clr),
    .en    (en),
    .mode  (mode),
    .d     (d),
    .sin_r (sin_r),
    .sin_l (sin_l),
    .rot   (rot),
    .q     (q),
    .so_r  (so_r),
    .so_l  (so_l),
    .cnt   (cnt),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle outputs before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [7:0] eq,
                             input logic [3:0] ecnt, input logic edone);
    check({tag, ".q"},    64'(q),    64'(eq));
    check({tag, ".cnt"},  64'(cnt),  64'(ecnt));
    check({tag, ".done"}, 64'(done), 64'(edone));
  endtask

  task automatic pulse_clr();
    #2 clr = 1'b1;
    #1;
    check_state("async_clr", 8'h00, 4'd0, 1'b0);
    @(negedge clk);
    clr = 1'b0;
  endtask

  logic [7:0] pat;
  logic [7:0] stream;

  initial begin
    clr = 1'b1; en = 1'b0; mode = 2'b00; d = '0;
    sin_r = 1'b0; sin_l = 1'b0; rot = 1'b0;
    #3;
    check_state("reset", 8'h00, 4'd0, 1'b0);
    @(negedge clk);
    clr = 1'b0;

    // Load A5, then asynchronous clear between edges
    en = 1'b1; mode = 2'b11; d = 8'hA5;
    step();
    check_state("load_a5", 8'hA5, 4'd0, 1'b0);
    mode = 2'b00;
    pulse_clr();

    // Load B4 then serialise right
    mode = 2'b11; d = 8'hB4;
    step();
    check_state("load_b4", 8'hB4, 4'd0, 1'b0);
    check("load_b4.so_l", 64'(so_l), 64'd1);
    mode = 2'b01; sin_r = 1'b0;
    pat = 8'hB4;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("shr.so_r[%0d]", i), 64'(so_r), 64'(pat[i]));
      step();
      check($sformatf("shr.cnt[%0d]", i), 64'(cnt), 64'(i + 1));
      check($sformatf("shr.done[%0d]", i), 64'(done), 64'(i == 7));
    end
    check_state("shr_end", 8'h00, 4'd8, 1'b1);

    // Deserialise left from reset
    mode = 2'b00;
    pulse_clr();
    mode = 2'b10;
    stream = 8'b1010_0110;
    for (int i = 0; i < 8; i++) begin
      sin_l = stream[7 - i];
      step();
      check($sformatf("shl.done[%0d]", i), 64'(done), 64'(i == 7));
    end
    check_state("shl_end", 8'hA6, 4'd8, 1'b1);
    sin_l = 1'b1;
    step();
    check_state("shl_sat", 8'h4D, 4'd8, 1'b1);

    // Enable low freezes everything, hold mode too
    en = 1'b0; mode = 2'b11; d = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check_state($sformatf("en0[%0d]", i), 8'h4D, 4'd8, 1'b1);
    end
    en = 1'b1; mode = 2'b00;
    step();
    check_state("hold", 8'h4D, 4'd8, 1'b1);

    // Load mid-serialisation
    mode = 2'b11; d = 8'h0F;
    step();
    check_state("load_0f", 8'h0F, 4'd0, 1'b0);
    mode = 2'b01; sin_r = 1'b0;
    step(); step(); step();
    check_state("shr3", 8'h01, 4'd3, 1'b0);
    mode = 2'b11; d = 8'hF0;
    step();
    check_state("reload_f0", 8'hF0, 4'd0, 1'b0);

    // Mixed direction shifts, then clear mid-operation
    mode = 2'b01; sin_r = 1'b1;
    step();
    mode = 2'b10; sin_l = 1'b0;
    step();
    check_state("mixed", 8'hF0, 4'd2, 1'b0);
    mode = 2'b00;
    pulse_clr();

    // Rotate select
    mode = 2'b11; d = 8'h81;
    step();
    mode = 2'b01; rot = 1'b1; sin_r = 1'b0;
    step();
`ifdef USR_ROTATE_EN
    check_state("rot1", 8'hC0, 4'd1, 1'b0);
`else
    check_state("rot1", 8'h40, 4'd1, 1'b0);
`endif
    for (int i = 0; i < 7; i++) step();
`ifdef USR_ROTATE_EN
    check_state("rot8", 8'h81, 4'd8, 1'b1);
`else
    check_state("rot8", 8'h00, 4'd8, 1'b1);
`endif
    rot = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
